if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage; drives the IF/ID register that feeds the decode stage.
//  Owns the PC and fetches 32-bit words through a req/done handshake with the memory controller.
//  Takes branch/jump redirects from EX and holds its output while the stall controller stalls.
//  Optional direct-mapped instruction cache removes the memory round-trip on a hit.
// PARAMETERS
//  RESET_PC     32'h0  PC loaded at reset
//  ICACHE_LINES 64     cache entries, power of 2; used only with ICACHE_EN
// PORTS
//  clk_in        in   1   clock, rising edge
//  rst_in        in   1   reset, asynchronous, active-low
//  stall_in      in   1   stall ctrl: 1 = IF/ID will not accept this cycle
//  jump_in       in   1   EX redirect, one-cycle pulse
//  jump_pc_in    in   32  redirect target; bits [1:0] ignored, forced to 0
//  mem_req_out   out  1   fetch request to memory controller
//  mem_addr_out  out  32  word address of fetch, bits [1:0]=0
//  mem_done_in   in   1   one-cycle pulse; mem_data_in valid this cycle
//  mem_data_in   in   32  fetched instruction word
//  pc_out        out  32  PC of instru_out
//  instru_out    out  32  instruction to IF/ID
//  valid_out     out  1   instru_out/pc_out valid
//  stallfrom_if  out  1   = ~valid_out, to stall ctrl
// BEHAVIOUR
//  - Reset (rst_in=0): pc=RESET_PC, state=IDLE, valid_out=0, pc_out=0, instru_out=0, mem_req_out=0, cache valid bits=0.
//  - States: IDLE, WAIT_MEM, DROP. mem_req_out=1 in WAIT_MEM and DROP; mem_addr_out=pc.
//  - Output slot free when valid_out==0 or (valid_out==1 && stall_in==0); consumed on that edge.
//  - Consumed with no new word loaded: valid_out<=0 at the edge.
//  - IDLE: slot free -> WAIT_MEM next cycle. Slot not free -> stay IDLE, outputs held.
//  - WAIT_MEM: req held until mem_done_in. On done: instru_out<=mem_data_in, pc_out<=pc,
//    valid_out<=1, pc<=pc+4 (mod 2^32, 32'hFFFFFFFC wraps to 0), -> IDLE.
//  - Word latency: 1 cycle IDLE + memory latency; valid_out rises the edge after done.
//  - valid_out is always 0 while in WAIT_MEM or DROP.
//  - jump_in has priority over all other events in every state:
//    pc<=jump_pc_in&~3, valid_out<=0 (held word discarded, even if stalled).
//    IDLE or WAIT_MEM with mem_done_in this cycle -> IDLE; returned data discarded.
//    WAIT_MEM without mem_done_in -> DROP.
//    DROP -> stays DROP; pc reloaded with the newest target.
//  - DROP: req held, addr = new pc; memory ignores the address change mid-transfer.
//    On mem_done_in: data discarded, no cache fill, -> IDLE.
//  - stall_in never aborts an in-flight request; it only blocks consumption and new issue.
//  - Reset mid-transfer: immediate return to reset values; the memory controller is reset together with this block.
// CONFIGURATION
//  ICACHE_EN defined:
//   - ICACHE_LINES entries: {valid, tag=pc[31:2+log2(LINES)], data}, index pc[1+log2(LINES):2].
//   - IDLE with slot free and hit: load output from cache, pc+=4, stay IDLE. No mem_req_out.
//     One word per cycle while hits continue and slot stays free.
//   - IDLE with slot free and miss -> WAIT_MEM.
//   - Fill on mem_done_in in WAIT_MEM only: never in DROP, never when jump_in is set that cycle.
//   - Hit lookup is suppressed in any cycle with jump_in=1.
//  ICACHE_EN undefined: no arrays; every fetch goes through WAIT_MEM.
// TESTING
//  1 Reset RESET_PC=0; mem returns 32'h00000013 3 cycles after req -> valid_out=1, pc_out=0; next mem_addr_out=4.
//  2 valid_out=1, stall_in=1 for 5 cycles -> outputs frozen, mem_req_out=0; release -> fetch of next PC starts.
//  3 WAIT_MEM pc=8, jump_in with jump_pc_in=32'h103 -> DROP, mem_addr_out=32'h100.
//    Stale mem_done discarded; next fetch 32'h100, pc_out=32'h100.
//  4 jump_in and mem_done_in in same cycle -> data dropped, valid_out=0, next mem_addr_out=target.
//  5 jump_pc_in=32'hFFFFFFFC -> pc_out=32'hFFFFFFFC, then next fetch address 0.
//  6 ICACHE_EN: loop 0..12 run twice -> second pass no mem_req_out, valid_out=1 every cycle with stall_in=0.

Source files
------------

// File: rtl/if_stage_if.sv
// if_stage_if: bus bundle of the instruction-fetch stage -- pipeline control,
// IF/ID output slot and the req/done fetch handshake with the memory controller.
interface if_stage_if;
  logic        stall_in;
  logic        jump_in;
  logic [31:0] jump_pc_in;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_done_in;
  logic [31:0] mem_data_in;
  logic [31:0] pc_out;
  logic [31:0] instru_out;
  logic        valid_out;
  logic        stallfrom_if;

  modport master (
    input  stall_in, jump_in, jump_pc_in, mem_done_in, mem_data_in,
    output mem_req_out, mem_addr_out, pc_out, instru_out, valid_out, stallfrom_if
  );

  modport slave (
    output stall_in, jump_in, jump_pc_in, mem_done_in, mem_data_in,
    input  mem_req_out, mem_addr_out, pc_out, instru_out, valid_out, stallfrom_if
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage; owns the PC, fetches words over req/done and
// fills the IF/ID slot. Optional direct-mapped I-cache is enabled with `define ICACHE_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ICACHE_LINES = 64
) (
  input  logic       clk_in,
  input  logic       rst_in,
  if_stage_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_DROP     = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] pc_out_r;
  logic [31:0] instru_r;
  logic        valid_r;
  logic        mem_req_s;

  logic        slot_free_s;
  logic [31:0] pc_inc_s;
  logic [31:0] jump_tgt_s;
  logic        fill_s;
  logic        hit_s;
  logic [31:0] hit_data_s;

  assign slot_free_s = ~valid_r | ~bus.stall_in;
  assign pc_inc_s    = pc_r + 32'd4;
  assign jump_tgt_s  = bus.jump_pc_in & 32'hFFFF_FFFC;
  // Only a clean WAIT_MEM completion is trusted; a redirect in the same cycle makes it stale.
  assign fill_s      = (state_r == ST_WAIT_MEM) & bus.mem_done_in & ~bus.jump_in;

`ifdef ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ICACHE_LINES-1:0] cvalid_r;
  logic [TAG_W-1:0]        ctag_r  [ICACHE_LINES];
  logic [31:0]             cdata_r [ICACHE_LINES];
  logic [IDX_W-1:0]        idx_s;
  logic [TAG_W-1:0]        tag_s;

  assign idx_s      = pc_r[IDX_W+1:2];
  assign tag_s      = pc_r[31:IDX_W+2];
  assign hit_s      = ~bus.jump_in & cvalid_r[idx_s] & (ctag_r[idx_s] == tag_s);
  assign hit_data_s = cdata_r[idx_s];

  // Cache line valid bits: cleared by reset, set on fill.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cvalid_r <= {ICACHE_LINES{1'b0}};
    end else if (fill_s) begin
      cvalid_r[idx_s] <= 1'b1;
    end else begin
      cvalid_r <= cvalid_r;
    end
  end

  // Cache tag/data storage, qualified by the valid bits so no reset is needed.
  always_ff @(posedge clk_in) begin
    if (fill_s) begin
      ctag_r[idx_s]  <= tag_s;
      cdata_r[idx_s] <= bus.mem_data_in;
    end
  end
`else
  logic cfg_unused_s;

  assign cfg_unused_s = (ICACHE_LINES > 0);
  assign hit_s        = 1'b0;
  assign hit_data_s   = 32'h0000_0000;
`endif

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a redirect outranks every other event.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.jump_in) begin
          state_nxt_s = ST_IDLE;
        end else if (slot_free_s && !hit_s) begin
          state_nxt_s = ST_WAIT_MEM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_MEM: begin
        if (bus.mem_done_in) begin
          state_nxt_s = ST_IDLE;
        end else if (bus.jump_in) begin
          state_nxt_s = ST_DROP;
        end else begin
          state_nxt_s = ST_WAIT_MEM;
        end
      end
      ST_DROP: begin
        if (bus.jump_in) begin
          state_nxt_s = ST_DROP;
        end else if (bus.mem_done_in) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode: the request stays up for the whole transfer, including a dropped one.
  always_comb begin
    mem_req_s = 1'b0;
    case (state_r)
      ST_WAIT_MEM: mem_req_s = 1'b1;
      ST_DROP:     mem_req_s = 1'b1;
      default:     mem_req_s = 1'b0;
    endcase
  end

  // PC and IF/ID output slot.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pc_r     <= RESET_PC;
      pc_out_r <= 32'h0000_0000;
      instru_r <= 32'h0000_0000;
      valid_r  <= 1'b0;
    end else if (bus.jump_in) begin
      pc_r    <= jump_tgt_s;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (slot_free_s && hit_s) begin
            instru_r <= hit_data_s;
            pc_out_r <= pc_r;
            valid_r  <= 1'b1;
            pc_r     <= pc_inc_s;
          end else if (slot_free_s) begin
            valid_r <= 1'b0;
          end else begin
            valid_r <= valid_r;
          end
        end
        ST_WAIT_MEM: begin
          if (bus.mem_done_in) begin
            instru_r <= bus.mem_data_in;
            pc_out_r <= pc_r;
            valid_r  <= 1'b1;
            pc_r     <= pc_inc_s;
          end else begin
            valid_r <= 1'b0;
          end
        end
        default: begin
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req_out  = mem_req_s;
  assign bus.mem_addr_out = pc_r;
  assign bus.pc_out       = pc_out_r;
  assign bus.instru_out   = instru_r;
  assign bus.valid_out    = valid_r;
  assign bus.stallfrom_if = ~valid_r;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: self-checking bench for if_stage with a latency-programmable memory
// responder and a program-order reference model of the fetched instruction stream.
module tb_if_stage;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   mem_lat = 3;
  bit   lat_random = 1'b0;

  if_stage_if bus_i ();

  if_stage #(.RESET_PC(32'h0000_0000), .ICACHE_LINES(64)) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus   (bus_i)
  );

  always #5 clk = ~clk;

  // Memory contents: address 0 holds a NOP, everything else a hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0000_0013;
    return (a ^ 32'hA5C3_0000) + 32'h0000_0101;
  endfunction

  // Memory controller model: latches the address when a request starts, answers after the latency.
  initial begin : mem_model
    bit          busy;
    int          cnt;
    logic [31:0] a;
    busy = 1'b0; cnt = 0; a = 32'h0;
    bus_i.mem_done_in = 1'b0;
    bus_i.mem_data_in = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus_i.mem_done_in = 1'b0;
      if (rst_n !== 1'b1) begin
        busy = 1'b0;
      end else if (busy) begin
        if (cnt <= 1) begin
          bus_i.mem_done_in = 1'b1;
          bus_i.mem_data_in = mem_word(a);
          busy = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end else if (bus_i.mem_req_out === 1'b1) begin
        busy = 1'b1;
        a = bus_i.mem_addr_out;
        cnt = lat_random ? int'($urandom_range(1, 4)) : mem_lat;
      end
    end
  end

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk); #2;
      if (bus_i.valid_out === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_i.stall_in = 1'b0; bus_i.jump_in = 1'b0; bus_i.jump_pc_in = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (bus_i.valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus_i.valid_out); end
    checks++; if (bus_i.pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc_out got=%h exp=0", bus_i.pc_out); end
    checks++; if (bus_i.instru_out !== 32'h0) begin failures++; $display("FAIL reset_instru got=%h exp=0", bus_i.instru_out); end
    checks++; if (bus_i.mem_req_out !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus_i.mem_req_out); end
    checks++; if (bus_i.mem_addr_out !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus_i.mem_addr_out); end
    checks++; if (bus_i.stallfrom_if !== 1'b1) begin failures++; $display("FAIL reset_stallfrom got=%b exp=1", bus_i.stallfrom_if); end
  endtask

  task automatic test_first_fetch();
    int          req_at;
    int          val_at;
    logic [31:0] first_addr;
    req_at = -1; val_at = -1; first_addr = 32'hDEAD_BEEF;
    mem_lat = 3; lat_random = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #2;
      if (req_at < 0 && bus_i.mem_req_out === 1'b1) begin
        req_at = i;
        first_addr = bus_i.mem_addr_out;
      end
      if (bus_i.valid_out === 1'b1) begin
        val_at = i;
        break;
      end
    end
    bus_i.stall_in = 1'b1;
    checks++; if (val_at < 0) begin failures++; $display("FAIL first_timeout got=none exp=valid within 30 cycles"); end
    checks++; if (first_addr !== 32'h0) begin failures++; $display("FAIL first_addr got=%h exp=0", first_addr); end
    checks++; if (val_at - req_at != mem_lat + 1) begin failures++; $display("FAIL first_latency got=%0d exp=%0d", val_at - req_at, mem_lat + 1); end
    checks++; if (bus_i.pc_out !== 32'h0) begin failures++; $display("FAIL first_pc got=%h exp=0", bus_i.pc_out); end
    checks++; if (bus_i.instru_out !== 32'h0000_0013) begin failures++; $display("FAIL first_instru got=%h exp=00000013", bus_i.instru_out); end
    checks++; if (bus_i.mem_addr_out !== 32'h4) begin failures++; $display("FAIL first_next_addr got=%h exp=4", bus_i.mem_addr_out); end
  endtask

  task automatic test_stall();
    bit ok;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      checks++;
      if (bus_i.valid_out !== 1'b1 || bus_i.pc_out !== 32'h0 || bus_i.instru_out !== 32'h13 || bus_i.mem_req_out !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold got=v%b pc%h i%h r%b exp=v1 pc0 i13 r0", bus_i.valid_out, bus_i.pc_out, bus_i.instru_out, bus_i.mem_req_out);
      end
    end
    bus_i.stall_in = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (bus_i.valid_out !== 1'b0 || bus_i.mem_req_out !== 1'b1 || bus_i.mem_addr_out !== 32'h4) begin
      failures++;
      $display("FAIL stall_release got=v%b r%b a%h exp=v0 r1 a4", bus_i.valid_out, bus_i.mem_req_out, bus_i.mem_addr_out);
    end
    wait_valid(20, ok);
    bus_i.stall_in = 1'b1;
    checks++; if (!ok) begin failures++; $display("FAIL stall_next_timeout got=none exp=valid"); end
    checks++; if (bus_i.pc_out !== 32'h4) begin failures++; $display("FAIL stall_next_pc got=%h exp=4", bus_i.pc_out); end
    checks++; if (bus_i.instru_out !== mem_word(32'h4)) begin failures++; $display("FAIL stall_next_instru got=%h exp=%h", bus_i.instru_out, mem_word(32'h4)); end
  endtask

  task automatic test_jump_drop();
    bit ok;
    mem_lat = 5;
    bus_i.stall_in = 1'b0;
    @(posedge clk); #2;
    checks++; if (bus_i.mem_req_out !== 1'b1 || bus_i.mem_addr_out !== 32'h8) begin failures++; $display("FAIL drop_setup got=r%b a%h exp=r1 a8", bus_i.mem_req_out, bus_i.mem_addr_out); end
    @(posedge clk); #2;
    bus_i.jump_in = 1'b1; bus_i.jump_pc_in = 32'h0000_0103;
    @(posedge clk); #2;
    bus_i.jump_in = 1'b0;
    checks++;
    if (bus_i.mem_req_out !== 1'b1 || bus_i.mem_addr_out !== 32'h100 || bus_i.valid_out !== 1'b0) begin
      failures++;
      $display("FAIL drop_state got=r%b a%h v%b exp=r1 a100 v0", bus_i.mem_req_out, bus_i.mem_addr_out, bus_i.valid_out);
    end
    wait_valid(40, ok);
    bus_i.stall_in = 1'b1;
    checks++; if (!ok) begin failures++; $display("FAIL drop_timeout got=none exp=valid"); end
    checks++; if (bus_i.pc_out !== 32'h100) begin failures++; $display("FAIL drop_pc got=%h exp=100", bus_i.pc_out); end
    checks++; if (bus_i.instru_out !== mem_word(32'h100)) begin failures++; $display("FAIL drop_instru got=%h exp=%h", bus_i.instru_out, mem_word(32'h100)); end
  endtask

  task automatic test_jump_done();
    bit          ok;
    bit          seen;
    logic [31:0] tgt;
    mem_lat = 2;
    tgt = 32'h0000_0400 + (32'($urandom_range(0, 63)) << 2);
    bus_i.stall_in = 1'b0;
    @(posedge clk); #2;
    checks++; if (bus_i.mem_req_out !== 1'b1 || bus_i.mem_addr_out !== 32'h104) begin failures++; $display("FAIL jd_setup got=r%b a%h exp=r1 a104", bus_i.mem_req_out, bus_i.mem_addr_out); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (bus_i.mem_done_in === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL jd_done_timeout got=none exp=mem_done"); end
    bus_i.jump_in = 1'b1; bus_i.jump_pc_in = tgt | 32'($urandom_range(0, 3));
    @(posedge clk); #2;
    bus_i.jump_in = 1'b0;
    checks++; if (bus_i.valid_out !== 1'b0 || bus_i.mem_req_out !== 1'b0) begin failures++; $display("FAIL jd_discard got=v%b r%b exp=v0 r0", bus_i.valid_out, bus_i.mem_req_out); end
    @(posedge clk); #2;
    checks++; if (bus_i.mem_req_out !== 1'b1 || bus_i.mem_addr_out !== tgt) begin failures++; $display("FAIL jd_refetch got=r%b a%h exp=r1 a%h", bus_i.mem_req_out, bus_i.mem_addr_out, tgt); end
    wait_valid(20, ok);
    bus_i.stall_in = 1'b1;
    checks++; if (!ok || bus_i.pc_out !== tgt || bus_i.instru_out !== mem_word(tgt)) begin failures++; $display("FAIL jd_word got=ok%b pc%h exp=ok1 pc%h", ok, bus_i.pc_out, tgt); end
  endtask

  task automatic test_wrap();
    bit ok;
    bus_i.jump_in = 1'b1; bus_i.jump_pc_in = 32'hFFFF_FFFF;
    @(posedge clk); #2;
    bus_i.jump_in = 1'b0;
    checks++; if (bus_i.valid_out !== 1'b0 || bus_i.mem_addr_out !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_jump got=v%b a%h exp=v0 aFFFFFFFC", bus_i.valid_out, bus_i.mem_addr_out); end
    wait_valid(20, ok);
    checks++; if (!ok || bus_i.pc_out !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc got=ok%b pc%h exp=ok1 pcFFFFFFFC", ok, bus_i.pc_out); end
    checks++; if (bus_i.instru_out !== mem_word(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_instru got=%h exp=%h", bus_i.instru_out, mem_word(32'hFFFF_FFFC)); end
    checks++; if (bus_i.mem_addr_out !== 32'h0 || bus_i.mem_req_out !== 1'b0) begin failures++; $display("FAIL wrap_next_addr got=a%h r%b exp=a0 r0", bus_i.mem_addr_out, bus_i.mem_req_out); end
    bus_i.stall_in = 1'b0;
    @(posedge clk); #2;
    checks++; if (bus_i.mem_req_out !== 1'b1 || bus_i.mem_addr_out !== 32'h0) begin failures++; $display("FAIL wrap_fetch0 got=r%b a%h exp=r1 a0", bus_i.mem_req_out, bus_i.mem_addr_out); end
    wait_valid(20, ok);
    bus_i.stall_in = 1'b1;
    checks++; if (!ok || bus_i.pc_out !== 32'h0 || bus_i.instru_out !== 32'h13) begin failures++; $display("FAIL wrap_word0 got=ok%b pc%h i%h exp=ok1 pc0 i13", ok, bus_i.pc_out, bus_i.instru_out); end
  endtask

  // Program-order model: every presented word must be the next PC in sequence,
  // where the sequence advances on consumption and restarts at each redirect target.
  task automatic test_random();
    logic [31:0] exp_pc, hold_pc, hold_ins, tgt;
    bit          hold, jumped, st, jp;
    int          consumed;
    exp_pc = 32'h0; hold_pc = 32'h0; hold_ins = 32'h0;
    hold = 1'b0; jumped = 1'b0; consumed = 0;
    lat_random = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checks++; if (bus_i.stallfrom_if !== ~bus_i.valid_out) begin failures++; $display("FAIL rnd_stallfrom got=%b exp=%b", bus_i.stallfrom_if, ~bus_i.valid_out); end
      if (jumped) begin
        checks++; if (bus_i.valid_out !== 1'b0) begin failures++; $display("FAIL rnd_jump_flush got=%b exp=0", bus_i.valid_out); end
      end
      if (hold) begin
        checks++;
        if (bus_i.valid_out !== 1'b1 || bus_i.pc_out !== hold_pc || bus_i.instru_out !== hold_ins) begin
          failures++; $display("FAIL rnd_hold got=v%b pc%h exp=v1 pc%h", bus_i.valid_out, bus_i.pc_out, hold_pc);
        end
      end
      if (bus_i.valid_out === 1'b1) begin
        checks++; if (bus_i.pc_out !== exp_pc) begin failures++; $display("FAIL rnd_pc got=%h exp=%h", bus_i.pc_out, exp_pc); end
        checks++; if (bus_i.instru_out !== mem_word(exp_pc)) begin failures++; $display("FAIL rnd_instru got=%h exp=%h", bus_i.instru_out, mem_word(exp_pc)); end
      end
      if (bus_i.mem_req_out === 1'b1) begin
        checks++;
        if (bus_i.valid_out !== 1'b0 || bus_i.mem_addr_out[1:0] !== 2'b00) begin
          failures++; $display("FAIL rnd_req_state got=v%b a%h exp=v0 aligned", bus_i.valid_out, bus_i.mem_addr_out);
        end
      end
      st = ($urandom_range(0, 99) < 40);
      jp = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else tgt = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(0, 3));
      bus_i.stall_in = st; bus_i.jump_in = jp; bus_i.jump_pc_in = tgt;
      hold = (bus_i.valid_out === 1'b1) && st && !jp;
      hold_pc = bus_i.pc_out; hold_ins = bus_i.instru_out; jumped = jp;
      if (jp) begin
        exp_pc = tgt & 32'hFFFF_FFFC;
      end else if (bus_i.valid_out === 1'b1 && !st) begin
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      @(posedge clk); #2;
    end
    bus_i.jump_in = 1'b0; bus_i.stall_in = 1'b0;
    checks++; if (consumed < 100) begin failures++; $display("FAIL rnd_progress got=%0d exp>=100", consumed); end
  endtask

`ifdef ICACHE_EN
  task automatic test_icache();
    localparam logic [31:0] BASE = 32'h0000_8000;
    bit found;
    lat_random = 1'b1;
    bus_i.stall_in = 1'b0;
    bus_i.jump_in = 1'b1; bus_i.jump_pc_in = BASE;
    @(posedge clk); #2;
    bus_i.jump_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus_i.valid_out === 1'b1 && bus_i.pc_out === BASE + 32'd48) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #2;
    end
    checks++; if (!found) begin failures++; $display("FAIL ic_pass1 got=none exp=pc %h", BASE + 32'd48); end
    bus_i.jump_in = 1'b1; bus_i.jump_pc_in = BASE;
    @(posedge clk); #2;
    bus_i.jump_in = 1'b0;
    checks++; if (bus_i.valid_out !== 1'b0 || bus_i.mem_req_out !== 1'b0) begin failures++; $display("FAIL ic_restart got=v%b r%b exp=v0 r0", bus_i.valid_out, bus_i.mem_req_out); end
    for (int k = 0; k < 13; k++) begin
      @(posedge clk); #2;
      checks++;
      if (bus_i.valid_out !== 1'b1 || bus_i.mem_req_out !== 1'b0 || bus_i.pc_out !== BASE + 32'(4 * k) || bus_i.instru_out !== mem_word(BASE + 32'(4 * k))) begin
        failures++;
        $display("FAIL ic_hit got=v%b r%b pc%h exp=v1 r0 pc%h", bus_i.valid_out, bus_i.mem_req_out, bus_i.pc_out, BASE + 32'(4 * k));
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    bit ok;
    bit found;
    lat_random = 1'b0; mem_lat = 4;
    bus_i.stall_in = 1'b0;
    bus_i.jump_in = 1'b1; bus_i.jump_pc_in = 32'h0000_0040;
    @(posedge clk); #2;
    bus_i.jump_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (bus_i.mem_req_out === 1'b1 && bus_i.mem_addr_out === 32'h40) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin failures++; $display("FAIL rm_setup got=none exp=req at 40"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_i.mem_req_out !== 1'b0 || bus_i.valid_out !== 1'b0 || bus_i.mem_addr_out !== 32'h0 || bus_i.pc_out !== 32'h0 || bus_i.instru_out !== 32'h0) begin
      failures++;
      $display("FAIL rm_async got=r%b v%b a%h pc%h exp=r0 v0 a0 pc0", bus_i.mem_req_out, bus_i.valid_out, bus_i.mem_addr_out, bus_i.pc_out);
    end
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    wait_valid(20, ok);
    checks++; if (!ok || bus_i.pc_out !== 32'h0 || bus_i.instru_out !== 32'h13) begin failures++; $display("FAIL rm_restart got=ok%b pc%h i%h exp=ok1 pc0 i13", ok, bus_i.pc_out, bus_i.instru_out); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_jump_drop();
    test_jump_done();
    test_wrap();
    test_random();
`ifdef ICACHE_EN
    test_icache();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
